// File: rtl/dct2d_sequencer.sv
// dct2d_sequencer: sequences a separable 8x8 2-D transform through an external
// 1-D core. It moves the 8 input rows through the core into a transpose buffer,
// then moves the 8 transpose rows through the core into the result buffer.
// Host access is through an Avalon-MM slave. The core wait is set by the CORE_WAIT parameter.
// Optional feature macro: DCT2D_SEQUENCER_IRQ_EN adds the ins_irq output.
module dct2d_sequencer #(
    parameter int unsigned CORE_WAIT = 1
) (
    input  logic         csi_clk,
    input  logic         rsi_reset_n,
    input  logic [7:0]   avs_s0_address,
    input  logic         avs_s0_write,
    input  logic [31:0]  avs_s0_writedata,
    input  logic         avs_s0_read,
    output logic [31:0]  avs_s0_readdata,
    output logic [127:0] dct_x,
    input  logic [127:0] dct_y
`ifdef DCT2D_SEQUENCER_IRQ_EN
    ,
    output logic         ins_irq
`endif
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned VEC_N  = 8;
    localparam int unsigned BLK_N  = 64;
    localparam int unsigned VEC_W  = 3;
    localparam int unsigned WAIT_W = 3;

    localparam logic [7:0] ADDR_CTRL   = 8'h80;
    localparam logic [7:0] ADDR_STATUS = 8'h81;

    typedef enum logic [2:0] {
        IDLE,
        ROW_LOAD,
        ROW_WAIT,
        ROW_STORE,
        COL_LOAD,
        COL_WAIT,
        COL_STORE
    } state_t;

    state_t              state_q, state_nxt;
    logic [VEC_W-1:0]    vec_q, vec_nxt;
    logic [WAIT_W-1:0]   wait_q, wait_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic                irq_en_q, irq_en_nxt;
    logic                load_c, store_row_c, store_col_c;

    logic [WORD_W-1:0]   in_buf    [BLK_N];
    logic [WORD_W-1:0]   trans_buf [BLK_N];
    logic [WORD_W-1:0]   res_buf   [BLK_N];

    logic [VEC_N*WORD_W-1:0] row_vec_c;
    logic [DATA_W-1:0]       rd_data_c;

    logic ctrl_wr_c, start_c, abort_c, in_wr_c;
    logic unused_wdata;

    assign ctrl_wr_c    = avs_s0_write && (avs_s0_address == ADDR_CTRL);
    assign start_c      = ctrl_wr_c && avs_s0_writedata[0];
    assign abort_c      = ctrl_wr_c && avs_s0_writedata[1];
    assign in_wr_c      = avs_s0_write && !busy_q && (avs_s0_address[7:6] == 2'b00);
    assign unused_wdata = ^avs_s0_writedata[31:16];

    // Next-state, counters and status flags; abort overrides everything.
    always_comb begin
        state_nxt   = state_q;
        vec_nxt     = vec_q;
        wait_nxt    = wait_q;
        busy_nxt    = busy_q;
        done_nxt    = done_q;
        irq_en_nxt  = ctrl_wr_c ? avs_s0_writedata[2] : irq_en_q;
        load_c      = 1'b0;
        store_row_c = 1'b0;
        store_col_c = 1'b0;
        if (abort_c) begin
            state_nxt = IDLE;
            vec_nxt   = '0;
            wait_nxt  = '0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_c) begin
                        state_nxt = ROW_LOAD;
                        vec_nxt   = '0;
                        wait_nxt  = '0;
                        busy_nxt  = 1'b1;
                        done_nxt  = 1'b0;
                    end
                end
                ROW_LOAD: begin
                    load_c    = 1'b1;
                    wait_nxt  = '0;
                    state_nxt = ROW_WAIT;
                end
                ROW_WAIT: begin
                    if (wait_q == WAIT_W'(CORE_WAIT - 1)) begin
                        state_nxt = ROW_STORE;
                    end else begin
                        wait_nxt = wait_q + 3'd1;
                    end
                end
                ROW_STORE: begin
                    store_row_c = 1'b1;
                    if (vec_q == 3'd7) begin
                        vec_nxt   = '0;
                        state_nxt = COL_LOAD;
                    end else begin
                        vec_nxt   = vec_q + 3'd1;
                        state_nxt = ROW_LOAD;
                    end
                end
                COL_LOAD: begin
                    load_c    = 1'b1;
                    wait_nxt  = '0;
                    state_nxt = COL_WAIT;
                end
                COL_WAIT: begin
                    if (wait_q == WAIT_W'(CORE_WAIT - 1)) begin
                        state_nxt = COL_STORE;
                    end else begin
                        wait_nxt = wait_q + 3'd1;
                    end
                end
                COL_STORE: begin
                    store_col_c = 1'b1;
                    if (vec_q == 3'd7) begin
                        vec_nxt   = '0;
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        vec_nxt   = vec_q + 3'd1;
                        state_nxt = COL_LOAD;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            wait_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            vec_q    <= vec_nxt;
            wait_q   <= wait_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            irq_en_q <= irq_en_nxt;
        end
    end

`ifdef DCT2D_SEQUENCER_IRQ_EN
    // Interrupt tracks done & irq_en, so start, abort and reset all drop it.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            ins_irq <= 1'b0;
        end else begin
            ins_irq <= done_nxt && irq_en_nxt;
        end
    end
`endif

    // Selects the vector for the core: input row in row phase, transpose row in column phase.
    always_comb begin
        row_vec_c = '0;
        for (int j = 0; j < VEC_N; j++) begin
            if (state_q == ROW_LOAD) begin
                row_vec_c[j*WORD_W +: WORD_W] = in_buf[{vec_q, 3'(j)}];
            end else begin
                row_vec_c[j*WORD_W +: WORD_W] = trans_buf[{vec_q, 3'(j)}];
            end
        end
    end

    // Core input register, loaded for one cycle per vector.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            dct_x <= '0;
        end else if (load_c) begin
            dct_x <= row_vec_c;
        end
    end

    // Host writes into the input block; writes while busy are dropped.
    always_ff @(posedge csi_clk) begin
        if (in_wr_c) begin
            in_buf[avs_s0_address[5:0]] <= avs_s0_writedata[WORD_W-1:0];
        end
    end

    // Row results land transposed: element k of row r goes to [k][r].
    always_ff @(posedge csi_clk) begin
        if (store_row_c) begin
            for (int k = 0; k < VEC_N; k++) begin
                trans_buf[{3'(k), vec_q}] <= dct_y[k*WORD_W +: WORD_W];
            end
        end
    end

    // Column results: element k of transpose row c goes to result [k][c].
    always_ff @(posedge csi_clk) begin
        if (store_col_c) begin
            for (int k = 0; k < VEC_N; k++) begin
                res_buf[{3'(k), vec_q}] <= dct_y[k*WORD_W +: WORD_W];
            end
        end
    end

    // Read decode; unmapped addresses return zero.
    always_comb begin
        rd_data_c = '0;
        unique case (avs_s0_address[7:6])
            2'b00: rd_data_c = DATA_W'(in_buf[avs_s0_address[5:0]]);
            2'b01: rd_data_c = DATA_W'(res_buf[avs_s0_address[5:0]]);
            default: begin
                if (avs_s0_address == ADDR_CTRL) begin
                    rd_data_c = {29'b0, irq_en_q, 2'b00};
                end else if (avs_s0_address == ADDR_STATUS) begin
                    rd_data_c = {29'b0, irq_en_q, done_q, busy_q};
                end
            end
        endcase
    end

    // Registered read data, held when no read is issued.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            avs_s0_readdata <= '0;
        end else if (avs_s0_read) begin
            avs_s0_readdata <= rd_data_c;
        end
    end

endmodule

// File: doc/dct2d_sequencer.md
DCT2D_SEQUENCER -- requirements
Module: dct2d_sequencer

Interface
REQ-001 SHALL have parameter CORE_WAIT, default 1: cycles between presenting a vector to the 1-D core and sampling its result (1..4).
REQ-002 SHALL have port csi_clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port rsi_reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port avs_s0_address  input  8  Avalon-MM word address.
REQ-005 SHALL have port avs_s0_write  input  1  write strobe.
REQ-006 SHALL have port avs_s0_writedata  input  32  write data.
REQ-007 SHALL have port avs_s0_read  input  1  read strobe.
REQ-008 SHALL have port avs_s0_readdata  output  32  registered read data.
REQ-009 SHALL have port dct_x  output  128  eight 16-bit core inputs, x0 in [15:0] .. x7 in [127:112].
REQ-010 SHALL have port dct_y  input  128  eight 16-bit core outputs, same packing.

Function
REQ-011 Address map SHALL be 0x00-0x3F input block (row*8+col, writedata[15:0]), 0x40-0x7F result block (read only), 0x80 CTRL, 0x81 STATUS.
REQ-012 CTRL write SHALL decode bit0=start, bit1=abort, bit2=irq_en (irq_en stored, others self-clearing).
REQ-013 STATUS read SHALL return {29'b0, irq_en, done, busy}. CTRL read returns {29'b0, irq_en, 2'b0}.
REQ-014 Reads SHALL update avs_s0_readdata one cycle after avs_s0_read: zero-extended 16-bit data, 0 for unmapped addresses. Without a read, it holds.
REQ-015 FSM states SHALL be IDLE, ROW_LOAD, ROW_WAIT, ROW_STORE, COL_LOAD, COL_WAIT, COL_STORE.
REQ-016 Start in IDLE SHALL clear done, set busy, zero the vector counter, and enter ROW_LOAD on the next edge.
REQ-017 ROW_LOAD SHALL register input row r onto dct_x (1 cycle). ROW_WAIT lasts CORE_WAIT cycles. ROW_STORE writes dct_y element k to transpose buffer [k][r] (1 cycle).
REQ-018 After ROW_STORE with r=7, the FSM SHALL enter COL_LOAD. Otherwise r increments and it returns to ROW_LOAD.
REQ-019 COL phase SHALL mirror the row phase using transpose row c and write dct_y element k to result [k][c]. After c=7 it returns to IDLE with busy=0, done=1.
REQ-020 busy SHALL be high for exactly 16*(2+CORE_WAIT) cycles per block (48 at CORE_WAIT=1).
REQ-021 Start while busy SHALL be ignored. Input-block writes while busy SHALL be dropped. Result reads while busy return current buffer contents.
REQ-022 Abort SHALL force IDLE on the next edge with busy=0, done=0. Abort wins over a simultaneous start.
REQ-023 Core arithmetic SHALL be external. The block SHALL only move 16-bit words, with no truncation or sign handling.

Reset
REQ-024 Reset SHALL asynchronously set state=IDLE, busy=0, done=0, irq_en=0, counters=0, dct_x=0, avs_s0_readdata=0.
REQ-025 Input, transpose and result buffers SHALL NOT be reset. Reset mid-block SHALL abandon the block.

Configuration
REQ-026 With macro DCT2D_SEQUENCER_IRQ_EN defined, the block SHALL add output ins_irq (1 bit) equal to registered done & irq_en, cleared by start, abort or reset.
REQ-027 Without DCT2D_SEQUENCER_IRQ_EN, ins_irq SHALL be absent. irq_en SHALL be still stored and readable, with no other effect.

Verification
REQ-028 Identity core stub (dct_y=dct_x), write input[i]=i+1 for i=0..63, start -> busy 48 cycles, then done=1 and result[i]=i+1 for all i.
REQ-029 Swap stub (y_k=x_(7-k)), input[i]=i -> result[r*8+c]=input[(7-r)*8+(7-c)].
REQ-030 Start at cycle 10 of a busy block, plus a write to 0x05 -> no restart, done after original 48 cycles, 0x05 unchanged.
REQ-031 Abort at cycle 20, and a separate simultaneous start+abort -> STATUS=0 next cycle in both cases.
REQ-032 Reset asserted mid-ROW_WAIT -> STATUS=0 and readdata=0 immediately, dct_x=0.
REQ-033 IRQ_EN build, irq_en=1 -> ins_irq rises with done, falls on the next start. Default build: ins_irq port absent.
